// File: rtl/contador_mod11_pkg.sv
`default_nettype none
// ============================================================================
// Module   : contador_mod11_pkg
// Purpose  : Shared Morse slot-counter constants.
// Revision : 1.0
// ============================================================================
package contador_mod11_pkg;

   localparam int MORSE_SLOT_MOD = 11;
   localparam int MORSE_SLOT_W   = 4;

endpackage : contador_mod11_pkg
`default_nettype wire

// File: rtl/contador_mod11.sv
`default_nettype none
// ============================================================================
// Module   : contador_mod11
// Purpose  : Modulo-MODULO up-counter with enable and async active-low reset.
// Revision : 1.0
// ============================================================================
module contador_mod11
   import contador_mod11_pkg::*;
#(
   parameter int MODULO = MORSE_SLOT_MOD,
   parameter int WIDTH  = MORSE_SLOT_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   output logic [WIDTH-1:0] salida
);

   localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULO - 1);

   generate
      if ((MODULO < 2) || ((2 ** WIDTH) < MODULO)) begin : g_bad_params
         $error("contador_mod11: MODULO must be >= 2 and fit in WIDTH bits");
      end
   endgenerate

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_next;

   // >= also folds any out-of-range value back to zero on the next enabled edge.
   always_comb begin
      w_next = r_count;
      if (EN) begin
         if (r_count >= c_last) begin
            w_next = '0;
         end else begin
            w_next = r_count + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_count <= '0;
      end else begin
         r_count <= w_next;
      end
   end

   assign salida = r_count;

endmodule : contador_mod11
`default_nettype wire

// File: tb/tb_contador_mod11.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_mod11
// Purpose  : Directed self-checking bench for contador_mod11 (11/4 and 5/3).
// Revision : 1.0
// ============================================================================
module tb_contador_mod11;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] salida;
   logic       rst5;
   logic       en5;
   logic [2:0] salida5;

   int n_vec  = 0;
   int n_miss = 0;

   contador_mod11 dut (
      .CLK    (clk),
      .RST    (rst),
      .EN     (en),
      .salida (salida)
   );

   contador_mod11 #(.MODULO(5), .WIDTH(3)) dut5 (
      .CLK    (clk),
      .RST    (rst5),
      .EN     (en5),
      .salida (salida5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One rising edge, then sample on the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst  = 1'b0;
      en   = 1'b1;
      rst5 = 1'b0;
      en5  = 1'b0;
      #1;
      check("reset_async_0", int'(salida), 0);

      // Reset hold with enable high
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("reset_hold_%0d", i), int'(salida), 0);
      end

      // Full sequence and wrap
      rst = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         check($sformatf("seq_%0d", i), int'(salida), i % 11);
      end

      // Async reset between edges at count 5 (currently 1)
      for (int i = 2; i <= 5; i++) tick();
      check("pre_async_5", int'(salida), 5);
      #2 rst = 1'b0;
      #1 check("async_clear_5", int'(salida), 0);
      @(negedge clk);
      rst = 1'b1;

      // Enable hold at 4
      for (int i = 1; i <= 4; i++) tick();
      check("pre_hold_4", int'(salida), 4);
      en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("hold4_%0d", i), int'(salida), 4);
      end
      en = 1'b1;
      tick();
      check("resume_5", int'(salida), 5);

      // Hold at terminal count
      for (int i = 6; i <= 10; i++) tick();
      check("pre_hold_10", int'(salida), 10);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("hold10_%0d", i), int'(salida), 10);
      end
      en = 1'b1;
      tick();
      check("wrap_from_hold", int'(salida), 0);

      // Reset mid-count at 7, 2 ns pulse off the clock grid
      for (int i = 1; i <= 7; i++) tick();
      check("pre_reset_7", int'(salida), 7);
      #2 rst = 1'b0;
      #1 check("midcount_clear", int'(salida), 0);
      #1 rst = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check($sformatf("after_reset_%0d", i), int'(salida), i);
      end

      // Parameter variant MODULO=5, WIDTH=3
      check("m5_reset", int'(salida5), 0);
      rst5 = 1'b1;
      en5  = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("m5_seq_%0d", i), int'(salida5), i % 5);
      end
      for (int i = 1; i <= 4; i++) tick();
      check("m5_pre_illegal", int'(salida5), 4);
      en5 = 1'b0;
      force dut5.r_count = 3'd6;
      #1 check("m5_forced", int'(salida5), 6);
      release dut5.r_count;
      en5 = 1'b1;
      tick();
      check("m5_illegal_recover", int'(salida5), 0);
      tick();
      check("m5_after_recover", int'(salida5), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_contador_mod11
`default_nettype wire

// File: doc/contador_mod11.md
Name: contador_mod11

Overview:
- Synchronous modulo-11 up-counter with count enable.
- Produces a 4-bit count that steps 0,1,…,10 and then wraps to 0.
- Used as a timing and sequencing counter in the Morse transmitter datapath, for example to step through symbol and element slots.
- Pure sequential block with no handshake and a single clock domain.

Parameters:
- MODULO, 11, number of distinct count states; the count runs 0..MODULO-1.
- WIDTH, 4, width of salida; must satisfy 2**WIDTH >= MODULO.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-low; RST=0 forces the count to 0 immediately.
- EN  input  1  count enable, active-high, sampled on the rising edge of CLK.
- salida  output  WIDTH (4)  current count value, registered.

Behaviour:
- Reset:
  - When RST=0, salida=0 asynchronously, with no dependence on CLK, and is held at 0 while RST=0.
  - Release is synchronous in effect: the first increment can occur on the first rising CLK edge at which RST=1 and EN=1.
- Count, on each rising CLK edge with RST=1:
  - EN=1 and salida<MODULO-1: salida <= salida+1.
  - EN=1 and salida==MODULO-1 (10): salida <= 0 (wrap). No extra state or stall cycle.
  - EN=0: salida holds its value. No drift and no wrap while disabled.
- Latency: the output reflects an increment one cycle after EN is sampled high. salida comes directly from the register, with no combinational path from EN to salida.
- Illegal states: if salida is ever >= MODULO (11..15, for example after X-propagation or SEU), the next enabled edge loads 0. While EN=0 the value holds.
- Simultaneous events: RST=0 overrides EN and CLK unconditionally. A rising CLK edge during an active reset has no effect.
- Reset mid-operation: asserting RST at any count value (including 10, just before wrap) returns salida to 0 at once. Counting resumes from 0 after release.
- Width: increment and compare are done at WIDTH bits. The wrap is an explicit compare against MODULO-1, not natural overflow.
- Elaboration check: the design must refuse to elaborate (generate-time error) if MODULO<2 or 2**WIDTH<MODULO.

Decomposition:
- Shared package holds:
  - MORSE_SLOT_MOD = 11
  - MORSE_SLOT_W = 4
- Other Morse blocks instantiate the counter with these values.
- No sub-module: the block is a single register plus next-state logic.

Test Plan:
- Reset hold: RST=0, EN=1, 10 clocks -> salida stays 0 throughout. Assert RST=0 between clock edges while salida=5 -> salida=0 before the next edge.
- Full sequence and wrap: RST=1, EN=1, 12 rising edges from 0 -> salida=1,2,…,10,0,1.
- Enable hold: count to 4, drop EN for 6 clocks -> salida stays 4. Raise EN -> 5 on the next edge.
- Hold at terminal: stop with EN=0 at salida=10 for 3 clocks -> stays 10. Raise EN -> 0 on the next edge.
- Reset mid-count: at salida=7, pulse RST=0 for 2 ns, not aligned to CLK -> salida=0 immediately. After release with EN=1 -> 1,2,3 on successive edges.
- Parameter variant: MODULO=5, WIDTH=3, EN=1 -> sequence 0,1,2,3,4,0. Force the register to 6 (illegal) -> next enabled edge gives 0.
